// File: rtl/seq_decoder.sv
// rtl/seq_decoder.sv - registered one-hot decoder with level, timed pulse and scan modes
`timescale 1ns/1ps
module seq_decoder #(
  parameter  int SEL_W  = 3,
  parameter  int HOLD_W = 4,
  localparam int OUT_W  = 2**SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  sel,
  input  logic [1:0]        mode,
  input  logic [HOLD_W-1:0] hold,
  input  logic              abort,
  output logic [OUT_W-1:0]  out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LEVEL, PULSE, SCAN} state_t;

  state_t              state_q, state_d;
  logic [OUT_W-1:0]    out_q, out_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                accept, cnt_zero, last_idx;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  assign accept   = in_valid && in_ready;
  assign cnt_zero = (cnt_q == '0);
  assign last_idx = (idx_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, LEVEL: begin
          if (accept) begin
            case (mode)
              2'b00:   state_d = LEVEL;
              2'b01:   state_d = PULSE;
              2'b10:   state_d = SCAN;
              default: state_d = IDLE;
            endcase
          end
        end
        PULSE:   if (cnt_zero) state_d = IDLE;
        SCAN:    if (cnt_zero && last_idx) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    out_d    = out_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    in_ready = (state_q == IDLE) || (state_q == LEVEL);
    busy_d   = (state_d == PULSE) || (state_d == SCAN);
    if (abort) begin
      out_d = '0;
    end else begin
      case (state_q)
        IDLE, LEVEL: begin
          if (accept) begin
            idx_d  = sel;
            cnt_d  = hold;
            hold_d = hold;
            out_d  = (mode == 2'b11) ? '0 : onehot(sel);
          end
        end
        PULSE: begin
          if (cnt_zero) begin
            out_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
        SCAN: begin
          // Each index gets hold+1 cycles; the count reloads from the latched hold.
          if (cnt_zero) begin
            if (last_idx) begin
              out_d  = '0;
              done_d = 1'b1;
            end else begin
              idx_d = idx_q + SEL_W'(1);
              out_d = onehot(idx_q + SEL_W'(1));
              cnt_d = hold_q;
            end
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
        default: out_d = '0;
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_decoder.sv
// tb/tb_seq_decoder.sv - scoreboard bench for seq_decoder with a cycle-plan reference model
`timescale 1ns/1ps
module tb_seq_decoder;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 4;
  localparam int OUT_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0, in_ready, abort = 1'b0, busy, done;
  logic [SEL_W-1:0]  sel = '0;
  logic [1:0]        mode = '0;
  logic [HOLD_W-1:0] hold = '0;
  logic [OUT_W-1:0]  out;

  seq_decoder #(.SEL_W(SEL_W), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .mode(mode), .hold(hold), .abort(abort), .out(out), .busy(busy), .done(done));

  logic        v1 = 1'b0, r1, a1 = 1'b0, b1, d1;
  logic [0:0]  sel1 = '0;
  logic [1:0]  mode1 = '0, out1;
  logic [3:0]  hold1 = '0;

  seq_decoder #(.SEL_W(1), .HOLD_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .sel(sel1),
    .mode(mode1), .hold(hold1), .abort(a1), .out(out1), .busy(b1), .done(d1));

  logic        v4 = 1'b0, r4, a4 = 1'b0, b4, d4;
  logic [3:0]  sel4 = '0, hold4 = '0;
  logic [1:0]  mode4 = '0;
  logic [15:0] out4;

  seq_decoder #(.SEL_W(4), .HOLD_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .sel(sel4),
    .mode(mode4), .hold(hold4), .abort(a4), .out(out4), .busy(b4), .done(d4));

  typedef struct packed {
    logic [OUT_W-1:0] out;
    logic             done;
    logic             busy;
    logic             rdy;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             plan[$];
  logic [OUT_W-1:0] level_v = '0;
  int               n_cmp = 0;
  int               n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected outputs after the next edge: a busy command expands into its whole
  // cycle-by-cycle plan up front, which later cycles simply replay.
  function automatic void model_step(input logic v, input int s, input int m, input int h,
                                     input logic a);
    exp_t e;
    int   last;
    if (a) begin
      plan.delete();
      level_v = '0;
      e = {8'h00, 1'b0, 1'b0, 1'b1};
    end else if (plan.size() > 0) begin
      e = plan.pop_front();
    end else if (v) begin
      if (m == 0) begin
        level_v = 8'(1) << s;
        e = {level_v, 1'b0, 1'b0, 1'b1};
      end else if (m == 3) begin
        level_v = '0;
        e = {8'h00, 1'b0, 1'b0, 1'b1};
      end else begin
        level_v = '0;
        last = (m == 1) ? s : OUT_W - 1;
        for (int i = s; i <= last; i++)
          for (int k = 0; k <= h; k++)
            plan.push_back({8'(1) << i, 1'b0, 1'b1, 1'b0});
        plan.push_back({8'h00, 1'b1, 1'b0, 1'b1});
        e = plan.pop_front();
      end
    end else begin
      e = {level_v, 1'b0, 1'b0, 1'b1};
    end
    exp_q.push_back(e);
  endfunction

  task automatic drive(input logic v, input int s, input int m, input int h, input logic a);
    @(negedge clk);
    in_valid = v;
    sel      = SEL_W'(s);
    mode     = 2'(m);
    hold     = HOLD_W'(h);
    abort    = a;
    model_step(v, s, m, h, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out", 32'(out), 32'(e.out));
        check("done", 32'(done), 32'(e.done));
        check("busy", 32'(busy), 32'(e.busy));
        check("in_ready", 32'(in_ready), 32'(e.rdy));
        check("onehot", 32'($countones(out) <= 1), 32'd1);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int hi;
    logic dn;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 5, 0, 0, 1'b0);
    idle(20);
    drive(1'b1, 2, 0, 0, 1'b0);
    idle(2);

    drive(1'b1, 3, 1, 2, 1'b0);
    repeat (4) drive(1'b1, 6, 0, 0, 1'b0);
    idle(2);

    drive(1'b1, 5, 2, 1, 1'b0);
    idle(7);
    drive(1'b1, 0, 1, 0, 1'b0);
    idle(2);

    drive(1'b1, 0, 2, 3, 1'b0);
    idle(5);
    drive(1'b1, 4, 0, 0, 1'b1);
    idle(2);
    drive(1'b1, 6, 0, 0, 1'b0);
    drive(1'b1, 0, 3, 0, 1'b0);
    idle(2);

    drive(1'b1, 2, 2, 1, 1'b0);
    idle(3);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    plan.delete();
    level_v = '0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 7, 1, 0, 1'b0);
    idle(2);

    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0));
    idle(40);
    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      v4 = 1'b1; sel4 = 4'(s); mode4 = 2'b00;
      @(posedge clk);
      #1;
      check("sweep4_out", 32'(out4), 32'(16'(1) << s));
      check("sweep4_hot", 32'($countones(out4)), 32'd1);
    end
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      v1 = 1'b1; sel1 = 1'(s); mode1 = 2'b00;
      @(posedge clk);
      #1;
      check("sweep1_out", 32'(out1), 32'(2'(1) << s));
      check("sweep1_hot", 32'($countones(out1)), 32'd1);
    end
    v1 = 1'b0;

    @(negedge clk);
    v4 = 1'b1; sel4 = 4'd9; mode4 = 2'b01; hold4 = 4'd15;
    hi = 0;
    dn = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      v4 = 1'b0;
      if (out4 == 16'h0200) hi++;
      if (d4) begin
        dn = 1'b1;
        break;
      end
    end
    check("hold15_high", 32'(hi), 32'd16);
    check("hold15_done", 32'(dn), 32'd1);
    check("hold15_out0", 32'(out4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_decoder.md
Name: seq_decoder

Overview:
Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready command interface. It adds sequential modes that the combinational decoders lack: level hold, timed pulse, and an auto-incrementing scan.
It sits between control logic and one-hot select targets (register-file write enables, chip selects, row strobes), where those targets need glitch-free registered selects and timed strobes.

Parameters:
SEL_W, 3, select index width; output width OUT_W = 2**SEL_W (derived, not overridable)
HOLD_W, 4, width of the per-index hold count

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  command present
in_ready  output  1  block can accept a command this cycle
sel  input  SEL_W  index to decode (start index in scan mode)
mode  input  2  00 level, 01 pulse, 10 scan, 11 clear
hold  input  HOLD_W  each active index asserts for hold+1 cycles (pulse/scan)
abort  input  1  synchronous cancel
out  output  OUT_W  registered one-hot select, or all-zero
busy  output  1  high in PULSE or SCAN state
done  output  1  one-cycle strobe when a pulse or scan completes

Behaviour:
- One clock domain; reset is asynchronous, active-low.
- Reset values: out=0, busy=0, done=0, state=IDLE, counters=0. in_ready=1 (combinational from state).
- Outputs registered. An accepted command (in_valid && in_ready at edge N) drives out from edge N+1.
- States: IDLE, LEVEL, PULSE, SCAN.
- in_ready = 1 in IDLE and LEVEL; 0 in PULSE and SCAN. in_valid is ignored while in_ready=0 (no queuing).
- Command decode on accept, from IDLE or LEVEL:
  - mode 00: out=1<<sel; go to LEVEL. out holds indefinitely. A new accept replaces out directly, with no zero cycle between.
  - mode 01: out=1<<sel; latch hold into the count; go to PULSE.
  - mode 10: out=1<<sel; latch hold and index; go to SCAN.
  - mode 11: out=0; go to IDLE.
- PULSE:
  - Count decrements each cycle. When count==0 at an edge: out=0, done=1 for that one cycle, go to IDLE.
  - Total out-high time is hold+1 cycles. hold=0 gives a single-cycle strobe.
- SCAN:
  - Each index is held hold+1 cycles, then the index increments and the count reloads from the latched hold.
  - After index OUT_W-1 completes its hold: out=0, done=1, go to IDLE. No wrap-around.
  - A start at sel=OUT_W-1 behaves like a pulse.
  - A mid-scan change on the hold input has no effect (latched value used).
- abort: highest priority below reset. At the next edge out=0, go to IDLE, done=0, and any same-cycle command is dropped.
- done is never asserted for LEVEL, clear or abort.
- busy = (state==PULSE || state==SCAN), registered with the state.
- At most one bit of out is ever high.
- Reset asserted mid-operation clears out immediately (asynchronous) and discards the latched index and count.
- sel is fully decoded, so every SEL_W value is legal. No X propagation from unused codes.

Test Plan:
- Reset then SEL_W=3, level sel=5 -> out=8'b0010_0000 one cycle after accept, held 20 cycles; then level sel=2 -> out=8'b0000_0100 next cycle, no zero gap.
- Pulse sel=3 hold=2 -> out=8'b0000_1000 for exactly 3 cycles; in_ready=0 and busy=1 throughout; done=1 on the cycle out returns to 0; in_valid during the pulse is ignored.
- Scan sel=5 hold=1 -> out walks 0x20,0x20,0x40,0x40,0x80,0x80, then 0 with done=1; pulse hold=0 sel=0 -> single-cycle out=0x01 plus done.
- Scan sel=0 hold=3, abort asserted in the 6th busy cycle with in_valid=1 -> next cycle out=0, state IDLE, done=0, command dropped; then clear (mode 11) from LEVEL -> out=0.
- rst_n dropped asynchronously (between edges) mid-scan -> out=0 and busy=0 immediately; after release, pulse sel=7 hold=0 -> out=0x80 for one cycle, done=1.
- Parameter sweep SEL_W=1,4 -> exhaustive level decode of all sel values with exactly one hot bit; pulse hold=2**HOLD_W-1 (15) -> 16 high cycles.
